// File: rtl/matrix_frame_capture.sv
// matrix_frame_capture: passive monitor on the 8x8 bicolor LED matrix scan bus.
// Rebuilds red/green frames from the row-scan stream into a working buffer.
// Each complete frame is committed to a display buffer, which is read back
// through a registered port.
//
// Optional feature macro: FRAME_CAP_CMP_EN (frame-change compare logic).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   row          scan row select, active-low one-hot
//   r_col/g_col  red/green column data for the selected row
//   rd_row       readback row index
//   rd_r/rd_g    registered readback of the display frame
//   frame_valid  at least one frame committed since reset
//   frame_done   one-cycle pulse on frame commit
//   row_err      one-cycle pulse on accepted illegal row pattern
//   err_cnt      saturating illegal-pattern count
//   frame_cnt    wrapping committed-frame count
//   frame_chg    one-cycle pulse with frame_done when the frame changed
module matrix_frame_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] row,
    input  logic [7:0] r_col,
    input  logic [7:0] g_col,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_r,
    output logic [7:0] rd_g,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       row_err,
    output logic [7:0] err_cnt,
    output logic [7:0] frame_cnt,
    output logic       frame_chg
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        CAPT = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [7:0]       r_row_q, r_rcol_q, r_gcol_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic [2:0]       r_exp, w_exp_nxt;

    logic [7:0][7:0]  r_work_r, r_work_g;
    logic [7:0][7:0]  r_disp_r, r_disp_g;
    logic [7:0][7:0]  w_frame_r, w_frame_g;

    logic [3:0] w_zeros;
    logic [2:0] w_idx;
    logic       w_legal, w_illegal, w_accept;
    logic       w_wr, w_commit, w_err, w_chg;

    // Input register and stability tracking. The counter is cleared on the
    // edge that loads a new row_q, so it counts stable cycles of row_q.
    // row_q resets to blank so an idle bus after reset is never an error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row_q  <= 8'hFF;
            r_rcol_q <= 8'h00;
            r_gcol_q <= 8'h00;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_row_q  <= row;
            r_rcol_q <= r_col;
            r_gcol_q <= g_col;
            if (row != r_row_q) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else begin
                if (r_cnt != SETTLE_C) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_accept) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    assign w_accept = r_armed && (r_cnt == SETTLE_C);

    // Row pattern classification: count zeros and locate the (last) zero.
    always_comb begin
        w_zeros = 4'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_row_q[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = 3'(i);
            end
        end
    end

    assign w_legal   = (w_zeros == 4'd1);
    assign w_illegal = (w_zeros != 4'd1) && (w_zeros != 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SYNC;
            r_exp   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    // Next-state logic; blank patterns fall through with no effect.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_wr        = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            if (w_illegal) begin
                w_err       = 1'b1;
                w_state_nxt = SYNC;
                w_exp_nxt   = 3'd0;
            end else if (w_legal) begin
                case (r_state)
                    SYNC: begin
                        if (w_idx == 3'd0) begin
                            w_wr        = 1'b1;
                            w_exp_nxt   = 3'd1;
                            w_state_nxt = CAPT;
                        end
                    end
                    CAPT: begin
                        if (w_idx == r_exp) begin
                            w_wr = 1'b1;
                            if (w_idx == 3'd7) begin
                                w_commit    = 1'b1;
                                w_state_nxt = SYNC;
                                w_exp_nxt   = 3'd0;
                            end else begin
                                w_exp_nxt = r_exp + 3'd1;
                            end
                        end else if (w_idx == 3'd0) begin
                            // Restart the frame from row 0.
                            w_wr      = 1'b1;
                            w_exp_nxt = 3'd1;
                        end else begin
                            w_state_nxt = SYNC;
                            w_exp_nxt   = 3'd0;
                        end
                    end
                    default: begin
                        w_state_nxt = SYNC;
                        w_exp_nxt   = 3'd0;
                    end
                endcase
            end
        end
    end

    // Working frame with the current row merged in; used for both the
    // working-buffer write and the commit so row 7 lands in the same cycle.
    always_comb begin
        w_frame_r        = r_work_r;
        w_frame_g        = r_work_g;
        w_frame_r[w_idx] = r_rcol_q;
        w_frame_g[w_idx] = r_gcol_q;
    end

    // Change detect against the frame currently on display.
`ifdef FRAME_CAP_CMP_EN
    assign w_chg = !frame_valid || (w_frame_r != r_disp_r) || (w_frame_g != r_disp_g);
`else
    assign w_chg = 1'b0;
`endif

    // Buffers, readback and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_work_r    <= '0;
            r_work_g    <= '0;
            r_disp_r    <= '0;
            r_disp_g    <= '0;
            rd_r        <= 8'h00;
            rd_g        <= 8'h00;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            row_err     <= 1'b0;
            err_cnt     <= 8'h00;
            frame_cnt   <= 8'h00;
            frame_chg   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_work_r <= w_frame_r;
                r_work_g <= w_frame_g;
            end
            if (w_commit) begin
                r_disp_r    <= w_frame_r;
                r_disp_g    <= w_frame_g;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end
            // Old display contents are read on a commit edge.
            rd_r       <= r_disp_r[rd_row];
            rd_g       <= r_disp_g[rd_row];
            frame_done <= w_commit;
            frame_chg  <= w_commit && w_chg;
            row_err    <= w_err;
            if (w_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/matrix_frame_capture.md
# matrix_frame_capture

Passive monitor on the 8x8 bicolor LED matrix bus (`row`, `r_col`, `g_col`) produced by the maze display driver. It reconstructs complete red/green frames from the row-scan stream and holds them in a double-buffered frame store. A registered readback port exposes the frame, together with frame/error status. It sits beside the matrix pins for on-board self-check and for bench scoreboarding of the game display.

## Interface
Parameters:
- `SETTLE`, default 2: number of consecutive cycles a row pattern must stay stable before its columns are sampled (1..15).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `row`  in  8  scan row select, active-low one-hot; bit i low = row i lit.
- `r_col`  in  8  red column data for the currently selected row.
- `g_col`  in  8  green column data for the currently selected row.
- `rd_row`  in  3  readback row index.
- `rd_r`  out  8  red data of the displayed frame at `rd_row`, registered.
- `rd_g`  out  8  green data of the displayed frame at `rd_row`, registered.
- `frame_valid`  out  1  high once at least one complete frame has been committed.
- `frame_done`  out  1  one-cycle pulse when a frame is committed.
- `row_err`  out  1  one-cycle pulse when an illegal row pattern is accepted.
- `err_cnt`  out  8  count of illegal patterns; saturates at 255.
- `frame_cnt`  out  8  count of committed frames; wraps from 255 to 0.
- `frame_chg`  out  1  one-cycle pulse with `frame_done` if the new frame differs from the previous one (see Configuration).

## Operation
- **Input register:** `row`, `r_col`, and `g_col` are registered once (`*_q`). All decisions use the registered copies.
- **Pattern classification of `row_q`:**
  - Exactly one zero: legal, with index 0..7.
  - All ones: blank. It is ignored; there is no capture, no error, and the FSM state is unchanged.
  - Anything else: illegal.
- **Stability counter:** reset to 0 whenever `row_q` differs from its value in the previous cycle; otherwise it increments, saturating at `SETTLE`. A pattern is accepted once, on the cycle the counter reaches `SETTLE`. An `armed` flag blocks re-acceptance until `row_q` changes.
- **FSM, states `SYNC` and `CAPT`, with expected index `exp`:**
  - `SYNC`: an accepted legal index 0 writes `r_col_q`/`g_col_q` into working buffer row 0, sets `exp`=1, and moves to `CAPT`. Any other accepted legal index is discarded.
  - `CAPT`: an accepted index equal to `exp` writes the working row and increments `exp`. When index 7 is written, the working buffer is copied to the display buffer, `frame_done` pulses, `frame_cnt` increments, `frame_valid` is set, and the FSM returns to `SYNC`.
  - `CAPT`, out-of-order legal index: if the index is 0, capture restarts at row 0 (stay in `CAPT`, `exp`=1); otherwise go to `SYNC`. No error is flagged.
  - Illegal pattern accepted (any state): `row_err` pulses, `err_cnt` increments (saturating), and the FSM goes to `SYNC`. The partial working frame is discarded; the display buffer is untouched.
- **Readback:** `rd_r`/`rd_g` are loaded every cycle from `display[rd_row]`. If a commit happens in the same cycle, the readback returns the pre-commit data.
- **Reset** (`rst`=0 at a clock edge): FSM goes to `SYNC`; the counter, `armed`, `exp`, and both buffers are cleared to 0; all outputs go to 0. Reset applied mid-frame abandons the frame.

## Timing
- Input to acceptance: acceptance occurs `SETTLE`+1 cycles after a new pattern appears on the pins (1 cycle for the input register, then `SETTLE` stable cycles).
- `frame_done`, `frame_chg`, and the `frame_cnt` update all fall in the same cycle, which is the cycle after row 7 is accepted. The display buffer holds the new frame from that cycle on.
- `row_err` and `err_cnt` update in the cycle after an illegal pattern is accepted.
- Readback latency: 1 cycle from `rd_row` to `rd_r`/`rd_g`.
- A row period shorter than `SETTLE`+1 cycles is never captured.

## Configuration
- `FRAME_CAP_CMP_EN` defined:
  - A 128-bit copy of the previous display frame is kept.
  - `frame_chg` pulses together with `frame_done` when any bit of the new frame differs from the previous one.
  - The first frame after reset always asserts `frame_chg`.
- `FRAME_CAP_CMP_EN` undefined: the compare logic is removed and `frame_chg` is tied to 0.

## Test plan
- Rows 0..7 in order, 4 cycles each, with `r_col`=8'hF8 on row 0, `g_col`=8'h01 on row 3, and all other columns 0 → one `frame_done` pulse, `frame_cnt`=1, `frame_valid`=1; `rd_row`=0 reads `rd_r`=8'hF8, `rd_row`=3 reads `rd_g`=8'h01.
- Stream starting at row 5 (5, 6, 7, 0..7) → exactly one `frame_done`, committed after the second row 7; no `row_err`.
- `row`=8'b1111_0011 held for 4 cycles mid-frame → `row_err` pulses once, `err_cnt`=1, no commit; the next full 0..7 sequence commits.
- Glitch: each legal row held for only 1 cycle with `SETTLE`=2 → no capture and `frame_cnt` stays 0. Blank 8'hFF inserted between rows → ignored, and the frame still commits.
- Two identical frames followed by a third with one bit changed → with `FRAME_CAP_CMP_EN`, `frame_chg` pulses on frames 1 and 3 only. Without it, `frame_chg` stays 0.
- Reset asserted after row 4 of a frame, then a full sequence → all outputs 0 during reset; after reset exactly one `frame_done`, `frame_cnt`=1; 300 illegal patterns → `err_cnt`=255.
